// File: rtl/toi2s_pkg.sv
// rtl/toi2s_pkg.sv - shared PWM types and limits for the toI2S register bank and PWM block
package toi2s_pkg;

   localparam int PWM_NCH_MAX    = 8;
   localparam int PWM_DUTY_W     = 8;
   localparam int PWM_PRESCALE_W = 8;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   // Register-bank view of one PWM configuration set (duty per channel, mode, prescale)
   typedef struct packed {
      logic [PWM_NCH_MAX-1:0][PWM_DUTY_W-1:0] duty;
      pwm_mode_e                              mode;
      logic [PWM_PRESCALE_W-1:0]              prescale;
   } pwm_shadow_t;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared prescaler and edge/center period counter for pwm_multi
module pwm_timebase
   import toi2s_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
)
(
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  enable,
   input  pwm_mode_e             act_mode,
   input  logic [PRESCALE_W-1:0] act_prescale,
   output logic [WIDTH-1:0]      cnt,
   output logic                  boundary
);

   localparam logic [WIDTH-1:0]      CMAX  = '1;
   localparam logic [WIDTH-1:0]      ONE_C = WIDTH'(1);
   localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] pcnt;
   logic                  dir_down;
   logic                  tick;
   logic [WIDTH-1:0]      cnt_nxt;
   logic                  dir_nxt;

   assign tick     = enable && (pcnt == act_prescale);
   // A period ends on whichever tick brings the counter back to zero
   assign boundary = tick && (cnt_nxt == '0);

   // Next counter value: sawtooth wraps, triangle turns at CMAX and at zero
   always_comb begin
      cnt_nxt = cnt + ONE_C;
      dir_nxt = 1'b0;
      if (act_mode == PWM_CENTER) begin
         if (dir_down) begin
            cnt_nxt = cnt - ONE_C;
            dir_nxt = 1'b1;
         end else if (cnt == CMAX) begin
            cnt_nxt = CMAX - ONE_C;
            dir_nxt = 1'b1;
         end
         if (cnt_nxt == '0) begin
            dir_nxt = 1'b0;
         end
      end
   end

   // Prescaler and counter state; everything parks at zero while disabled
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pcnt     <= '0;
         cnt      <= '0;
         dir_down <= 1'b0;
      end else if (!enable) begin
         pcnt     <= '0;
         cnt      <= '0;
         dir_down <= 1'b0;
      end else if (tick) begin
         pcnt     <= '0;
         cnt      <= cnt_nxt;
         dir_down <= dir_nxt;
      end else begin
         pcnt     <= pcnt + ONE_P;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel double-buffered PWM; PWM_POLARITY_EN adds per-channel output polarity
module pwm_multi
   import toi2s_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
)
(
   input  logic                  clk,
   input  logic                  resetb,
   input  logic                  enable,
   input  logic                  mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [NCH*WIDTH-1:0]  duty,
   input  logic                  duty_load,
`ifdef PWM_POLARITY_EN
   input  logic [NCH-1:0]        polarity,
`endif
   output logic [NCH-1:0]        pwm_out,
   output logic                  period_start,
   output logic                  load_pending
);

   logic [NCH*WIDTH-1:0]  sh_duty;
   logic [NCH*WIDTH-1:0]  act_duty;
   pwm_mode_e             sh_mode;
   pwm_mode_e             act_mode;
   logic [PRESCALE_W-1:0] sh_prescale;
   logic [PRESCALE_W-1:0] act_prescale;
   logic [NCH-1:0]        act_pol;
   logic [WIDTH-1:0]      cnt;
   logic                  boundary;
   logic                  take_active;

   logic [NCH*WIDTH-1:0]  ld_duty;
   pwm_mode_e             ld_mode;
   logic [PRESCALE_W-1:0] ld_prescale;

`ifdef PWM_POLARITY_EN
   logic [NCH-1:0]        sh_pol;
   logic [NCH-1:0]        ld_pol;
`else
   assign act_pol = '0;
`endif

   pwm_timebase #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) u_timebase (
      .clk          (clk),
      .resetb       (resetb),
      .enable       (enable),
      .act_mode     (act_mode),
      .act_prescale (act_prescale),
      .cnt          (cnt),
      .boundary     (boundary)
   );

   // Active set is refreshed at a period boundary, or straight away while idle
   assign take_active = boundary || (!enable && load_pending && !duty_load);

   // A load landing on the boundary cycle bypasses the shadow
   always_comb begin
      ld_duty     = duty_load ? duty : sh_duty;
      ld_mode     = duty_load ? pwm_mode_e'(mode) : sh_mode;
      ld_prescale = duty_load ? prescale : sh_prescale;
`ifdef PWM_POLARITY_EN
      ld_pol      = duty_load ? polarity : sh_pol;
`endif
   end

   // Shadow capture, active-set transfer and pending flag
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         sh_duty      <= '0;
         sh_mode      <= PWM_EDGE;
         sh_prescale  <= '0;
         act_duty     <= '0;
         act_mode     <= PWM_EDGE;
         act_prescale <= '0;
         load_pending <= 1'b0;
`ifdef PWM_POLARITY_EN
         sh_pol       <= '0;
         act_pol      <= '0;
`endif
      end else begin
         if (duty_load) begin
            sh_duty     <= duty;
            sh_mode     <= pwm_mode_e'(mode);
            sh_prescale <= prescale;
`ifdef PWM_POLARITY_EN
            sh_pol      <= polarity;
`endif
         end
         if (take_active) begin
            act_duty     <= ld_duty;
            act_mode     <= ld_mode;
            act_prescale <= ld_prescale;
`ifdef PWM_POLARITY_EN
            act_pol      <= ld_pol;
`endif
         end
         if (take_active) begin
            load_pending <= 1'b0;
         end else if (duty_load) begin
            load_pending <= 1'b1;
         end
      end
   end

   // Registered per-channel compare and period-start pulse
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pwm_out      <= '0;
         period_start <= 1'b0;
      end else begin
         period_start <= boundary;
         for (int i = 0; i < NCH; i++) begin
            pwm_out[i] <= enable ? ((cnt < act_duty[i*WIDTH +: WIDTH]) ^ act_pol[i]) : act_pol[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi against a period-position reference model
module tb_pwm_multi;

   localparam int NCH   = 4;
   localparam int WIDTH = 8;
   localparam int PW    = 8;
   localparam int CMAX  = (1 << WIDTH) - 1;

   logic                 clk       = 1'b0;
   logic                 resetb    = 1'b0;
   logic                 enable    = 1'b0;
   logic                 mode      = 1'b0;
   logic [PW-1:0]        prescale  = '0;
   logic [NCH*WIDTH-1:0] duty      = '0;
   logic                 duty_load = 1'b0;
`ifdef PWM_POLARITY_EN
   logic [NCH-1:0]       polarity  = '0;
`endif
   logic [NCH-1:0]       pwm_out;
   logic                 period_start;
   logic                 load_pending;

   pwm_multi #(.NCH(NCH), .WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .enable       (enable),
      .mode         (mode),
      .prescale     (prescale),
      .duty         (duty),
      .duty_load    (duty_load),
`ifdef PWM_POLARITY_EN
      .polarity     (polarity),
`endif
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .load_pending (load_pending)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: position k within the period, cnt derived arithmetically
   int             m_k, m_pre;
   int             a_duty [NCH];
   int             s_duty [NCH];
   int             a_mode, s_mode, a_ps, s_ps;
   logic [NCH-1:0] a_pol, s_pol;
   bit             m_pend;
   logic [NCH-1:0] e_pwm;
   bit             e_ps;

   // Per-period statistics measured from the DUT outputs
   int acc_hi [NCH];
   int acc_len;
   bit acc_tr [2048];
   bit win_valid;
   int rec_n;
   int rec_hi [4][NCH];
   int rec_len [4];
   bit rec_sym [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int per_len(input int md);
      return (md != 0) ? 2 * CMAX : CMAX + 1;
   endfunction

   function automatic int cnt_at(input int k, input int md);
      return (md == 0 || k <= CMAX) ? k : 2 * CMAX - k;
   endfunction

   function automatic bit boundary_next();
      return enable && (m_pre == a_ps) && ((m_k + 1) == per_len(a_mode));
   endfunction

   task automatic clear_acc();
      acc_len = 0;
      for (int i = 0; i < NCH; i++) acc_hi[i] = 0;
   endtask

   task automatic model_reset();
      m_k = 0; m_pre = 0; a_mode = 0; s_mode = 0; a_ps = 0; s_ps = 0;
      a_pol = '0; s_pol = '0; m_pend = 0; e_pwm = '0; e_ps = 0;
      for (int i = 0; i < NCH; i++) begin a_duty[i] = 0; s_duty[i] = 0; end
      win_valid = 0;
      clear_acc();
   endtask

   task automatic model_edge();
      int c;
      bit bnd;
      int in_d [NCH];
      logic [NCH-1:0] in_pol;
      for (int i = 0; i < NCH; i++) in_d[i] = int'(duty[i*WIDTH +: WIDTH]);
      in_pol = '0;
`ifdef PWM_POLARITY_EN
      in_pol = polarity;
`endif
      bnd = boundary_next();
      if (!enable) begin
         e_pwm = a_pol;
         m_k = 0;
         m_pre = 0;
      end else begin
         c = cnt_at(m_k, a_mode);
         for (int i = 0; i < NCH; i++) e_pwm[i] = (c < a_duty[i]) ^ a_pol[i];
         if (m_pre == a_ps) begin
            m_pre = 0;
            m_k = (m_k + 1) % per_len(a_mode);
         end else begin
            m_pre++;
         end
      end
      e_ps = bnd;
      if (bnd && duty_load) begin
         for (int i = 0; i < NCH; i++) a_duty[i] = in_d[i];
         a_mode = int'(mode); a_ps = int'(prescale); a_pol = in_pol;
         m_pend = 0;
      end else if (bnd || (!enable && m_pend && !duty_load)) begin
         for (int i = 0; i < NCH; i++) a_duty[i] = s_duty[i];
         a_mode = s_mode; a_ps = s_ps; a_pol = s_pol;
         m_pend = 0;
      end else if (duty_load) begin
         m_pend = 1;
      end
      if (duty_load) begin
         for (int i = 0; i < NCH; i++) s_duty[i] = in_d[i];
         s_mode = int'(mode); s_ps = int'(prescale); s_pol = in_pol;
      end
   endtask

   task automatic step();
      bit sym;
      @(posedge clk);
      model_edge();
      #1;
      check("pwm_out", 32'(pwm_out), 32'(e_pwm));
      check("period_start", 32'(period_start), 32'(e_ps));
      check("load_pending", 32'(load_pending), 32'(m_pend));
      if (!enable) begin
         win_valid = 0;
         clear_acc();
      end else begin
         if (acc_len < 2048) acc_tr[acc_len] = pwm_out[0];
         acc_len++;
         for (int i = 0; i < NCH; i++) acc_hi[i] += int'(pwm_out[i]);
         if (period_start) begin
            if (win_valid && rec_n < 4) begin
               sym = 1;
               for (int j = 1; j < acc_len && j < 2048; j++)
                  if (acc_tr[j] != acc_tr[acc_len - j]) sym = 0;
               for (int i = 0; i < NCH; i++) rec_hi[rec_n][i] = acc_hi[i];
               rec_len[rec_n] = acc_len;
               rec_sym[rec_n] = sym;
               rec_n++;
            end
            win_valid = 1;
            clear_acc();
         end
      end
   endtask

   task automatic run_periods(input int n, input bit discard);
      int cyc;
      cyc = 0;
      rec_n = 0;
      if (discard) win_valid = 0;
      while (rec_n < n && cyc < 20000) begin
         step();
         cyc++;
      end
      check("periods_seen", 32'(rec_n), 32'(n));
   endtask

   task automatic load(input logic [NCH*WIDTH-1:0] d, input logic md, input logic [PW-1:0] ps);
      duty = d;
      mode = md;
      prescale = ps;
      duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      step();
   endtask

   task automatic check_window(input int w, input logic [NCH*WIDTH-1:0] d, input int md, input int ps);
      int dv, hi;
      check($sformatf("win%0d_len", w), 32'(rec_len[w]), 32'(per_len(md) * (ps + 1)));
      for (int i = 0; i < NCH; i++) begin
         dv = int'(d[i*WIDTH +: WIDTH]);
         if (md != 0) hi = (dv > 0) ? 2 * dv - 1 : 0;
         else hi = dv;
         check($sformatf("win%0d_hi_ch%0d", w, i), 32'(rec_hi[w][i]), 32'(hi * (ps + 1)));
      end
   endtask

   task automatic wait_boundary();
      int cyc;
      cyc = 0;
      while (!boundary_next() && cyc < 5000) begin
         step();
         cyc++;
      end
      check("boundary_found", 32'(boundary_next()), 32'd1);
   endtask

   initial begin
      logic [NCH*WIDTH-1:0] vec;
      int cyc, md, ps;

      model_reset();
      rec_n = 0;
      resetb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pwm_out", 32'(pwm_out), 32'd0);
      check("reset_period_start", 32'(period_start), 32'd0);
      check("reset_load_pending", 32'(load_pending), 32'd0);
      @(negedge clk);
      resetb = 1'b1;

      // Edge mode, duties 0/64/128/255, loaded while idle
      load({8'd255, 8'd128, 8'd64, 8'd0}, 1'b0, 8'd0);
      enable = 1'b1;
      run_periods(2, 1);
      check_window(0, {8'd255, 8'd128, 8'd64, 8'd0}, 0, 0);
      check_window(1, {8'd255, 8'd128, 8'd64, 8'd0}, 0, 0);

      // Center mode, applied at the next boundary
      vec = {8'd254, 8'd50, 8'd1, 8'd100};
      load(vec, 1'b1, 8'd0);
      run_periods(1, 1);
      check_window(0, vec, 1, 0);
      check("center_symmetry", 32'(rec_sym[0]), 32'd1);

      // Prescaled edge mode
      load({4{8'd128}}, 1'b0, 8'd3);
      run_periods(2, 1);
      check_window(0, {4{8'd128}}, 0, 3);
      check_window(1, {4{8'd128}}, 0, 3);

      // Mid-period load is deferred to the next period
      load({4{8'd200}}, 1'b0, 8'd0);
      run_periods(1, 1);
      check_window(0, {4{8'd200}}, 0, 0);
      repeat (100) step();
      load({4{8'd32}}, 1'b0, 8'd0);
      check("pending_after_load", 32'(load_pending), 32'd1);
      run_periods(1, 0);
      check_window(0, {4{8'd200}}, 0, 0);
      check("pending_cleared", 32'(load_pending), 32'd0);
      run_periods(1, 0);
      check_window(0, {4{8'd32}}, 0, 0);

      // Load on the boundary cycle bypasses the shadow
      wait_boundary();
      load({4{8'd77}}, 1'b0, 8'd0);
      check("no_pending_bypass", 32'(load_pending), 32'd0);
      run_periods(1, 0);
      check_window(0, {4{8'd77}}, 0, 0);

      // Two loads in one period: last one wins
      repeat (50) step();
      load({4{8'd10}}, 1'b0, 8'd0);
      repeat (50) step();
      load({4{8'd90}}, 1'b0, 8'd0);
      run_periods(1, 0);
      check_window(0, {4{8'd77}}, 0, 0);
      run_periods(1, 0);
      check_window(0, {4{8'd90}}, 0, 0);

      // Enable dropped mid-period, then re-enabled
      repeat (30) step();
      enable = 1'b0;
      step();
      check("pwm_idle", 32'(pwm_out), 32'd0);
      check("period_start_idle", 32'(period_start), 32'd0);
      repeat (5) step();
      enable = 1'b1;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!period_start && cyc < 2000);
      check("first_period_len", 32'(cyc), 32'd256);

      // Asynchronous reset between clock edges while outputs are high
      repeat (2) step();
      check("pwm_high_before_reset", 32'(pwm_out), 32'hF);
      @(posedge clk);
      #3;
      resetb = 1'b0;
      #1;
      check("async_reset_pwm_out", 32'(pwm_out), 32'd0);
      check("async_reset_period_start", 32'(period_start), 32'd0);
      check("async_reset_load_pending", 32'(load_pending), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      repeat (3) step();

      // Randomized configurations loaded at random points
      for (int t = 0; t < 4; t++) begin
         vec = $urandom;
         md = int'($urandom_range(0, 1));
         ps = int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 300)) step();
         load(vec, md[0], ps[PW-1:0]);
         run_periods(2, 1);
         check_window(0, vec, md, ps);
         check_window(1, vec, md, ps);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
